// File: rtl/ext_mem_sram_bridge_if.sv
// Request/ack bus between snap_reg's mem side and the SRAM bridge.
// master drives requests and accepts acks; slave is the bridge.
interface ext_mem_sram_bridge_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 128
);
  logic                  req_vld;
  logic                  req_rdy;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  ack_vld;
  logic                  ack_rdy;
  logic                  ack_err;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output req_vld, wr_en, rd_en, addr, wr_data, ack_rdy,
    input  req_rdy, ack_vld, ack_err, rd_data
  );

  modport slave (
    input  req_vld, wr_en, rd_en, addr, wr_data, ack_rdy,
    output req_rdy, ack_vld, ack_err, rd_data
  );
endinterface

// File: rtl/ext_mem_sram_bridge.sv
// Terminates the mem-side request bus onto a single-port sync SRAM.
// Base strip, word indexing, strobe sequencing and error acks.
module ext_mem_sram_bridge #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 128,
  parameter int MEM_ADDR_WIDTH = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h20,
  parameter int RD_LATENCY     = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  ext_mem_sram_bridge_if.slave      bus,
  output logic                      sram_ce,
  output logic                      sram_we,
  output logic [MEM_ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0]     sram_wdata,
  input  logic [DATA_WIDTH-1:0]     sram_rdata
);

  localparam int BYTE_OFS = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] REGION =
    ADDR_WIDTH'(1) << (MEM_ADDR_WIDTH + BYTE_OFS);
  localparam logic [ADDR_WIDTH-1:0] ALIGN =
    ADDR_WIDTH'((1 << BYTE_OFS) - 1);
  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    ACK
  } state_t;

  state_t                state;
  logic [2:0]            cnt;
  logic                  op_wr;
  logic [ADDR_WIDTH-1:0] ofs;
  logic                  err;

  assign ofs = bus.addr - BASE_ADDR;

  // underflow is judged on the raw address, not the wrapped offset
  always_comb begin
    err = 1'b0;
    err = (bus.addr < BASE_ADDR)
        | (ofs >= REGION)
        | ((ofs & ALIGN) != '0)
        | (bus.wr_en == bus.rd_en);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      op_wr       <= 1'b0;
      bus.req_rdy <= 1'b1;
      bus.ack_vld <= 1'b0;
      bus.ack_err <= 1'b0;
      bus.rd_data <= '0;
      sram_ce     <= 1'b0;
      sram_we     <= 1'b0;
      sram_addr   <= '0;
      sram_wdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_vld) begin
            bus.req_rdy <= 1'b0;
            op_wr       <= bus.wr_en;
            if (err) begin
              bus.ack_vld <= 1'b1;
              bus.ack_err <= 1'b1;
              bus.rd_data <= '0;
              state       <= ACK;
            end else begin
              sram_ce    <= 1'b1;
              sram_we    <= bus.wr_en;
              sram_addr  <= ofs[BYTE_OFS +: MEM_ADDR_WIDTH];
              sram_wdata <= bus.wr_data;
              state      <= ACCESS;
            end
          end
        end
        ACCESS: begin
          sram_ce <= 1'b0;
          sram_we <= 1'b0;
          if (op_wr) begin
            bus.ack_vld <= 1'b1;
            bus.ack_err <= 1'b0;
            state       <= ACK;
          end else begin
            cnt   <= LAT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 3'd1) begin
            bus.rd_data <= sram_rdata;
            bus.ack_vld <= 1'b1;
            bus.ack_err <= 1'b0;
            state       <= ACK;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ACK: begin
          if (bus.ack_rdy) begin
            bus.ack_vld <= 1'b0;
            bus.req_rdy <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_mem_sram_bridge.sv
// Bench for ext_mem_sram_bridge: transaction model + directed vectors.
// Second instance exercises a 3-cycle read latency.
module tb_ext_mem_sram_bridge;

  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] PAT_A = {32{4'ha}};
  localparam logic [127:0] PAT_B = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ext_mem_sram_bridge_if #(.ADDR_WIDTH(64), .DATA_WIDTH(128)) b1 ();
  ext_mem_sram_bridge_if #(.ADDR_WIDTH(64), .DATA_WIDTH(128)) b3 ();

  logic         s1_ce, s1_we, s3_ce, s3_we;
  logic [0:0]   s1_addr, s3_addr;
  logic [127:0] s1_wdata, s1_rdata, s3_wdata, s3_rdata;

  ext_mem_sram_bridge #(.RD_LATENCY(1)) u_dut (
    .clk(clk), .rstn(rstn), .bus(b1),
    .sram_ce(s1_ce), .sram_we(s1_we), .sram_addr(s1_addr),
    .sram_wdata(s1_wdata), .sram_rdata(s1_rdata)
  );

  ext_mem_sram_bridge #(.RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .bus(b3),
    .sram_ce(s3_ce), .sram_we(s3_we), .sram_addr(s3_addr),
    .sram_wdata(s3_wdata), .sram_rdata(s3_rdata)
  );

  // SRAM macros: one with 1-edge read latency, one with 3
  logic [127:0] mem1 [2];
  logic [127:0] mem3 [2];
  logic [127:0] p3 [3];

  always @(posedge clk) begin
    if (s1_ce && s1_we) mem1[s1_addr] = s1_wdata;
    else if (s1_ce) s1_rdata <= mem1[s1_addr];
  end

  always @(posedge clk) begin
    if (s3_ce && s3_we) mem3[s3_addr] = s3_wdata;
    p3[0] <= mem3[s3_addr];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign s3_rdata = p3[2];

  int checks = 0;
  int errors = 0;
  int ce_cnt = 0;

  task automatic chk(input string n, input logic [127:0] a,
                     input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) if (s1_ce === 1'b1) ce_cnt++;

  // transaction-level model of instance 1
  logic [127:0] shadow [2];
  bit           m_on = 0;
  bit           m_busy, m_err, m_wr;
  int           m_t, m_lat;
  int           m_idx;
  logic [127:0] m_data, m_rd;
  logic [63:0]  a;

  always @(posedge clk) begin
    if (!rstn) begin
      m_on   = 1;
      m_busy = 0;
      m_rd   = '0;
    end else if (m_on) begin
      if (m_busy) begin
        if (m_t >= m_lat && b1.ack_rdy) m_busy = 0;
        else begin
          m_t++;
          if (m_t == m_lat && !m_wr && !m_err) m_rd = shadow[m_idx];
        end
      end else if (b1.req_vld) begin
        a      = b1.addr;
        m_err  = (a < 64'h20) || (a - 64'h20 >= 64'd32) ||
                 (a % 16 != 0) || (b1.wr_en == b1.rd_en);
        m_wr   = b1.wr_en;
        m_busy = 1;
        m_t    = 0;
        m_idx  = int'((a - 64'h20) / 16) % 2;
        m_data = b1.wr_data;
        m_lat  = m_err ? 0 : (m_wr ? 1 : 2);
        if (m_err) m_rd = '0;
        else if (m_wr) shadow[m_idx] = m_data;
      end
    end
  end

  always @(negedge clk) begin
    bit ea, ec;
    if (m_on) begin
      ea = m_busy && m_t >= m_lat;
      ec = m_busy && !m_err && m_t == 0;
      chk("m_req_rdy", 128'(b1.req_rdy), 128'(!m_busy));
      chk("m_ack_vld", 128'(b1.ack_vld), 128'(ea));
      chk("m_sram_ce", 128'(s1_ce), 128'(ec));
      chk("m_sram_we", 128'(s1_we), 128'(ec && m_wr));
      chk("m_rd_data", b1.rd_data, m_rd);
      if (ea) chk("m_ack_err", 128'(b1.ack_err), 128'(m_err));
      if (ec) chk("m_sram_addr", 128'(s1_addr), 128'(m_idx));
      if (ec && m_wr) chk("m_sram_wdata", s1_wdata, m_data);
    end
  end

  task automatic txn(input bit wr, input bit rd, input logic [63:0] ad,
                     input logic [127:0] d, input int hold,
                     output int lat, output logic [127:0] rdv,
                     output logic errv);
    int n;
    lat  = -1;
    rdv  = 'x;
    errv = 1'bx;
    n    = 0;
    @(negedge clk);
    while (!b1.req_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_rdy_wait", 128'(b1.req_rdy), 128'd1);
    b1.ack_rdy = (hold == 0);
    b1.req_vld = 1'b1;
    b1.wr_en   = wr;
    b1.rd_en   = rd;
    b1.addr    = ad;
    b1.wr_data = d;
    @(posedge clk);
    #1;
    b1.req_vld = 1'b0;
    b1.wr_en   = ~wr;
    b1.addr    = 64'hdead_beef;
    b1.wr_data = ~d;
    n = 0;
    @(negedge clk);
    while (!b1.ack_vld && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ack_wait", 128'(b1.ack_vld), 128'd1);
    if (b1.ack_vld) begin
      lat  = n;
      rdv  = b1.rd_data;
      errv = b1.ack_err;
      if (hold > 0) begin
        b1.req_vld = 1'b1;
        repeat (hold) begin
          @(negedge clk);
          chk("bp_ack_vld", 128'(b1.ack_vld), 128'd1);
          chk("bp_rd_data", b1.rd_data, rdv);
          chk("bp_req_rdy", 128'(b1.req_rdy), 128'd0);
        end
        b1.req_vld = 1'b0;
        b1.ack_rdy = 1'b1;
      end
      @(negedge clk);
      chk("idle_after_ack", 128'(b1.req_rdy), 128'd1);
    end
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    logic [63:0] ad;
  } ev_t;

  initial begin
    int           lat, c0, n;
    logic [127:0] rdv;
    logic         ev;
    ev_t          errs [5];

    errs[0] = '{0, 1, 64'h10};
    errs[1] = '{1, 0, 64'h40};
    errs[2] = '{0, 1, 64'h24};
    errs[3] = '{1, 1, 64'h20};
    errs[4] = '{0, 0, 64'h20};

    mem1[0] = PAT_A;  mem1[1] = '0;
    mem3[0] = PAT_A;  mem3[1] = '0;
    shadow[0] = PAT_A; shadow[1] = '0;
    s1_rdata = '0;
    b1.req_vld = 0; b1.wr_en = 0; b1.rd_en = 0;
    b1.addr = '0; b1.wr_data = '0; b1.ack_rdy = 1;
    b3.req_vld = 0; b3.wr_en = 0; b3.rd_en = 0;
    b3.addr = '0; b3.wr_data = '0; b3.ack_rdy = 1;

    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_rdy", 128'(b1.req_rdy), 128'd1);
    chk("rst_ack_vld", 128'(b1.ack_vld), 128'd0);
    chk("rst_ack_err", 128'(b1.ack_err), 128'd0);
    chk("rst_rd_data", b1.rd_data, 128'd0);
    chk("rst_ce_we", {s1_ce, s1_we}, 128'd0);
    chk("rst_sram_addr", 128'(s1_addr), 128'd0);
    chk("rst_sram_wdata", s1_wdata, 128'd0);
    rstn = 1'b1;

    c0 = ce_cnt;
    txn(1, 0, 64'h30, ONES, 0, lat, rdv, ev);
    chk("wr_lat", 128'(lat), 128'd1);
    chk("wr_err", 128'(ev), 128'd0);
    chk("wr_strobes", 128'(ce_cnt - c0), 128'd1);
    chk("wr_mem1", mem1[1], ONES);

    txn(0, 1, 64'h20, '0, 0, lat, rdv, ev);
    chk("rd1_lat", 128'(lat), 128'd2);
    chk("rd1_data", rdv, PAT_A);
    chk("rd1_err", 128'(ev), 128'd0);

    foreach (errs[i]) begin
      c0 = ce_cnt;
      txn(errs[i].wr, errs[i].rd, errs[i].ad, ONES, 0, lat, rdv, ev);
      chk($sformatf("err%0d_lat", i), 128'(lat), 128'd0);
      chk($sformatf("err%0d_flag", i), 128'(ev), 128'd1);
      chk($sformatf("err%0d_rd", i), rdv, 128'd0);
      chk($sformatf("err%0d_strobes", i), 128'(ce_cnt - c0), 128'd0);
    end

    txn(0, 1, 64'h30, '0, 5, lat, rdv, ev);
    chk("bp_data", rdv, ONES);

    @(negedge clk);
    b1.req_vld = 1; b1.rd_en = 1; b1.wr_en = 0; b1.addr = 64'h20;
    @(posedge clk);
    #1 b1.req_vld = 0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("mr_req_rdy", 128'(b1.req_rdy), 128'd1);
    chk("mr_ack_vld", 128'(b1.ack_vld), 128'd0);
    chk("mr_rd_data", b1.rd_data, 128'd0);
    chk("mr_ce", 128'(s1_ce), 128'd0);
    rstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("mr_no_ack", 128'(b1.ack_vld), 128'd0);
    end

    c0 = ce_cnt;
    txn(1, 0, 64'h20, PAT_B, 0, lat, rdv, ev);
    chk("post_rst_wr_lat", 128'(lat), 128'd1);
    chk("post_rst_wr_err", 128'(ev), 128'd0);
    chk("post_rst_strobes", 128'(ce_cnt - c0), 128'd1);

    txn(1, 0, 64'h20, ~PAT_B, 0, lat, rdv, ev);
    txn(0, 1, 64'h20, '0, 0, lat, rdv, ev);
    chk("b2b_data", rdv, ~PAT_B);

    @(negedge clk);
    b3.req_vld = 1; b3.rd_en = 1; b3.wr_en = 0; b3.addr = 64'h20;
    @(posedge clk);
    #1 b3.req_vld = 0;
    n = 0;
    @(negedge clk);
    while (!b3.ack_vld && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("rd3_lat", 128'(n), 128'd4);
    chk("rd3_data", b3.rd_data, PAT_A);
    chk("rd3_err", 128'(b3.ack_err), 128'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
